// File: rtl/tick_monitor.sv
// -----------------------------------------------------------------------------
// tick_monitor
//
// Purpose:
//   Receiving-end checker for a single-cycle tick enable from the clock
//   divider. It measures the clk-cycle interval between consecutive rising
//   edges of tick_in and reports each interval. It declares lock when two
//   consecutive intervals agree within TOLERANCE. It flags loss of tick after
//   TIMEOUT cycles without an edge, and it pulses stuck for every extra cycle
//   that tick_in is held high. One instance is used per tick net.
//
// Parameters:
//   WIDTH      width of the interval counter and of period (TIMEOUT < 2**WIDTH)
//   TIMEOUT    longest accepted interval in clk cycles
//   TOLERANCE  largest |interval - previous interval| that still counts as locked
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   tick_in       monitored tick, synchronous to clk
//   period        last measured interval in clk cycles
//   period_valid  one-cycle pulse when period is updated
//   locked        level, last two intervals within TOLERANCE
//   timeout       level, no tick edge for TIMEOUT cycles
//   stuck         one-cycle pulse per cycle tick_in stays high after its first
//
// States:
//   state | meaning
//   IDLE  | no edge seen since reset; waiting for the first edge
//   COUNT | measuring the interval since the last edge
//   LOST  | no edge within TIMEOUT cycles; counter frozen until the next edge
// -----------------------------------------------------------------------------
module tick_monitor #(
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 1_000_000,
  parameter int TOLERANCE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LOST  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH:0]   TOL   = (WIDTH+1)'(TOLERANCE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state;
  logic             tick_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] prev;
  logic             prev_valid;

  logic             edge_ev;
  logic             at_limit;
  logic [WIDTH:0]   diff;
  logic             within_tol;

  // The difference is formed one bit wider than the operands and always as
  // larger minus smaller, so it can never wrap.
  always_comb begin
    edge_ev  = tick_in & ~tick_q;
    at_limit = (cnt == LIMIT);
    diff     = '0;
    if (cnt >= prev) begin
      diff = {1'b0, cnt} - {1'b0, prev};
    end else begin
      diff = {1'b0, prev} - {1'b0, cnt};
    end
    within_tol = prev_valid && (diff <= TOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      // tick_q keeps following tick_in through reset so that a tick held
      // high across reset release is not mistaken for a fresh edge.
      tick_q       <= tick_in;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      tick_q       <= tick_in;
      stuck        <= tick_in & tick_q;
      period_valid <= 1'b0;

      // cnt is the number of cycles since the last edge; frozen while lost.
      if (edge_ev) begin
        cnt <= ONE;
      end else if (state != LOST) begin
        cnt <= cnt + ONE;
      end

      // An edge coinciding with cnt == LIMIT wins: it is a valid interval.
      case (state)
        IDLE: begin
          if (edge_ev) begin
            state <= COUNT;
          end else if (at_limit) begin
            state      <= LOST;
            timeout    <= 1'b1;
            locked     <= 1'b0;
            prev_valid <= 1'b0;
          end
        end

        COUNT: begin
          if (edge_ev) begin
            period       <= cnt;
            period_valid <= 1'b1;
            locked       <= within_tol;
            prev         <= cnt;
            prev_valid   <= 1'b1;
          end else if (at_limit) begin
            state      <= LOST;
            timeout    <= 1'b1;
            locked     <= 1'b0;
            prev_valid <= 1'b0;
          end
        end

        LOST: begin
          // The interval that ends a loss is not reported; measuring
          // restarts from this edge.
          if (edge_ev) begin
            state   <= COUNT;
            timeout <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_monitor.sv
module tb_tick_monitor;

  localparam int WIDTH     = 16;
  localparam int TIMEOUT   = 50;
  localparam int TOLERANCE = 2;

  logic             clk;
  logic             rst;
  logic             tick_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic             stuck;

  int checks = 0;
  int errors = 0;
  int stuck_cnt = 0;

  tick_monitor #(
    .WIDTH    (WIDTH),
    .TIMEOUT  (TIMEOUT),
    .TOLERANCE(TOLERANCE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout),
    .stuck       (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on absolute cycle numbers. An interval is the
  // difference between the cycle numbers of two rising edges; loss is declared
  // when TIMEOUT cycles pass after the last edge (or after reset) with none.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int anchor = 0;          // cycle of the last edge; cycles since = cyc - anchor
  bit seen = 0;            // an edge has been seen since reset
  bit lost = 0;
  bit have_prev = 0;
  int prev_iv = 0;
  int iv;
  int d;
  bit m_tq = 0;
  bit ev;
  int m_period = 0;
  bit m_pv = 0, m_locked = 0, m_timeout = 0, m_stuck = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_period  = 0;
      m_pv      = 0;
      m_locked  = 0;
      m_timeout = 0;
      m_stuck   = 0;
      seen      = 0;
      lost      = 0;
      have_prev = 0;
      prev_iv   = 0;
      anchor    = cyc + 1;   // the counter reads 0 on the first cycle out of reset
      m_tq      = tick_in;
    end else begin
      ev      = tick_in && !m_tq;
      m_stuck = tick_in && m_tq;
      m_pv    = 0;
      if (ev) begin
        if (seen && !lost) begin
          iv       = cyc - anchor;
          d        = (iv > prev_iv) ? iv - prev_iv : prev_iv - iv;
          m_period = iv;
          m_pv     = 1;
          m_locked = have_prev && (d <= TOLERANCE);
          prev_iv  = iv;
          have_prev = 1;
        end
        lost      = 0;
        m_timeout = 0;
        seen      = 1;
        anchor    = cyc;
      end else if (!lost && (cyc - anchor == TIMEOUT)) begin
        lost      = 1;
        m_timeout = 1;
        m_locked  = 0;
        have_prev = 0;
      end
      m_tq = tick_in;
    end
    #1;
    if (stuck) stuck_cnt++;
    chk("period", 32'(period), m_period);
    chk("period_valid", 32'(period_valid), 32'(m_pv));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("stuck", 32'(stuck), 32'(m_stuck));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: values are set on the falling edge and sampled on the
  // next rising edge; each call of drive covers n rising edges.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      tick_in = v;
    end
  endtask

  // Rising edge, check the outputs it produced, then stay low so the next
  // edge comes gap cycles later.
  task automatic edge_chk(input int gap, input int e_valid, input int e_period,
                          input int e_locked, input int e_timeout);
    drive(1'b1, 1);
    @(negedge clk);
    tick_in = 1'b0;
    chk("edge_period_valid", 32'(period_valid), e_valid);
    if (e_valid != 0) chk("edge_period", 32'(period), e_period);
    chk("edge_locked", 32'(locked), e_locked);
    chk("edge_timeout", 32'(timeout), e_timeout);
    drive(1'b0, gap - 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_period_valid"}, 32'(period_valid), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_stuck"}, 32'(stuck), 0);
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, jit, gap, hold, r;
    rst     = 1'b1;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Periodic ticks every 10 cycles.
    edge_chk(10, 0, 0, 0, 0);
    edge_chk(10, 1, 10, 0, 0);
    repeat (20) edge_chk(10, 1, 10, 1, 0);

    // Jitter: intervals 12, 15, 15 after a run of 10s.
    edge_chk(12, 1, 10, 1, 0);
    edge_chk(15, 1, 12, 1, 0);
    edge_chk(15, 1, 15, 0, 0);
    edge_chk(10, 1, 15, 1, 0);
    edge_chk(10, 1, 10, 0, 0);
    edge_chk(10, 1, 10, 1, 0);

    // Loss: last edge, then silence; timeout shows 51 cycles after the edge.
    drive(1'b1, 1);
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      tick_in = 1'b0;
      if (k == 50) chk("loss_timeout_early", 32'(timeout), 0);
      if (k == 51) begin
        chk("loss_timeout", 32'(timeout), 1);
        chk("loss_locked", 32'(locked), 0);
      end
    end
    drive(1'b0, 20);
    edge_chk(10, 0, 0, 0, 0);
    edge_chk(10, 1, 10, 0, 0);
    edge_chk(10, 1, 10, 1, 0);

    // Boundary: an interval of exactly TIMEOUT is accepted.
    edge_chk(50, 1, 10, 1, 0);
    edge_chk(10, 1, 50, 0, 0);
    edge_chk(10, 1, 10, 0, 0);
    edge_chk(10, 1, 10, 1, 0);
    // One past TIMEOUT: loss is raised and the ending interval is dropped.
    drive(1'b1, 1);
    drive(1'b0, 49);
    @(negedge clk);
    tick_in = 1'b0;
    chk("bound51_timeout_early", 32'(timeout), 0);
    @(negedge clk);
    chk("bound51_timeout", 32'(timeout), 1);
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    chk("bound51_timeout_clear", 32'(timeout), 0);
    chk("bound51_no_period", 32'(period_valid), 0);
    chk("bound51_locked", 32'(locked), 0);
    drive(1'b0, 8);
    edge_chk(10, 1, 10, 0, 0);
    edge_chk(10, 1, 10, 1, 0);

    // Stuck tick: held high for 4 cycles inside a 10-cycle stream.
    stuck_cnt = 0;
    drive(1'b1, 4);
    drive(1'b0, 6);
    edge_chk(10, 1, 10, 1, 0);
    chk("stuck_count", 32'(stuck_cnt), 3);

    // Reset while locked with tick_in high.
    chk("pre_reset_locked", 32'(locked), 1);
    @(negedge clk);
    tick_in = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midreset");
    drive(1'b1, 2);
    drive(1'b0, 3);
    edge_chk(10, 0, 0, 0, 0);
    edge_chk(10, 1, 10, 0, 0);
    edge_chk(10, 1, 10, 1, 0);

    // Randomized traffic checked cycle by cycle against the model.
    base = 10;
    for (int i = 0; i < 300; i++) begin
      if (i % 20 == 0) base = int'($urandom_range(4, 30));
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        @(negedge clk);
        rst     = 1'b1;
        tick_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst = 1'b0;
      end else if (r < 6) begin
        drive(1'b0, int'($urandom_range(50, 120)));
      end else begin
        if (r < 12) begin
          gap = int'($urandom_range(45, 56));
        end else begin
          jit = int'($urandom_range(0, 3));
          gap = base + int'($urandom_range(0, 2 * jit)) - jit;
        end
        hold = (r >= 90) ? int'($urandom_range(2, gap - 1)) : 1;
        drive(1'b1, hold);
        drive(1'b0, gap - hold);
      end
    end
    drive(1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
